// File: rtl/nco_pkg.sv
// Shared types and default parameters for the QAM16 carrier NCO sequencer.
package nco_pkg;

    localparam int unsigned FTW_W_DEF      = 32;
    localparam int unsigned POW_W_DEF      = 10;
    localparam int unsigned SETTLE_CYC_DEF = 8;
    localparam logic [FTW_W_DEF-1:0] FTW_DEFAULT_DEF = 32'h0800_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_t;

endpackage

// File: rtl/nco_seq_ctrl_if.sv
// Configuration offer/accept channel into the NCO sequencer.
interface nco_seq_ctrl_if
    import nco_pkg::*;
#(
    parameter int unsigned FTW_W = FTW_W_DEF,
    parameter int unsigned POW_W = POW_W_DEF
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [FTW_W-1:0] cfg_ftw;
    logic [POW_W-1:0] cfg_pow;

    modport master (output cfg_valid, output cfg_ftw, output cfg_pow, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_ftw, input  cfg_pow, output cfg_ready);
endinterface

// File: rtl/nco_cfg_shadow.sv
// Shadow FTW/POW holding, pending flag and registered cfg_ready for the sequencer.
module nco_cfg_shadow
    import nco_pkg::*;
#(
    parameter int unsigned FTW_W = FTW_W_DEF,
    parameter int unsigned POW_W = POW_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  state_t           state,
    input  state_t           state_nxt,
    input  logic             sym_stb,
    input  logic             cfg_valid,
    input  logic [FTW_W-1:0] cfg_ftw,
    input  logic [POW_W-1:0] cfg_pow,
    output logic             cfg_ready,
    output logic             pending,
    output logic [FTW_W-1:0] shadow_ftw,
    output logic [POW_W-1:0] shadow_pow,
    output logic             take_idle_c,
    output logic             apply_c
);

    logic take_c;
    logic pending_nxt;
    logic ready_nxt;

    // Apply needs RUN held through the edge so a run_en drop discards the shadow.
    always_comb begin
        take_c      = cfg_valid & cfg_ready;
        take_idle_c = take_c && (state == IDLE);
        apply_c     = pending && sym_stb && (state == RUN) && (state_nxt == RUN);
        pending_nxt = pending;
        if (state_nxt == IDLE) begin
            pending_nxt = 1'b0;
        end else if (apply_c) begin
            pending_nxt = 1'b0;
        end else if (take_c && ((state == SETTLE) || (state == RUN))) begin
            pending_nxt = 1'b1;
        end
        ready_nxt = (state_nxt == IDLE) ||
                    (((state_nxt == SETTLE) || (state_nxt == RUN)) && !pending_nxt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending    <= 1'b0;
            cfg_ready  <= 1'b1;
            shadow_ftw <= '0;
            shadow_pow <= '0;
        end else begin
            pending   <= pending_nxt;
            cfg_ready <= ready_nxt;
            if (take_c && (state != IDLE)) begin
                shadow_ftw <= cfg_ftw;
                shadow_pow <= cfg_pow;
            end
        end
    end

endmodule

// File: rtl/nco_seq_ctrl.sv
// Sequencer for the QAM16 carrier NCO: clear, settle, run, symbol-aligned retunes.
// Optional FTW sweep is built when NCO_SWEEP_EN is defined.
module nco_seq_ctrl
    import nco_pkg::*;
#(
    parameter int unsigned      FTW_W       = FTW_W_DEF,
    parameter int unsigned      POW_W       = POW_W_DEF,
    parameter logic [FTW_W-1:0] FTW_DEFAULT = FTW_W'(FTW_DEFAULT_DEF),
    parameter int unsigned      SETTLE_CYC  = SETTLE_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_en,
    input  logic             sym_stb,
    input  logic             nco_valid,
    nco_seq_ctrl_if.slave    cfg,
`ifdef NCO_SWEEP_EN
    input  logic             sweep_on,
    input  logic [FTW_W-1:0] sweep_step,
    input  logic [FTW_W-1:0] sweep_stop,
`endif
    output logic             nco_en,
    output logic             nco_clr,
    output logic [FTW_W-1:0] nco_ftw,
    output logic [POW_W-1:0] nco_pow,
    output logic             carrier_valid,
    output logic             upd_done,
    output logic             err
);

    localparam int unsigned CNT_W = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYC - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             en_nxt, clr_nxt, cv_nxt, upd_nxt, err_nxt;
    logic [FTW_W-1:0] ftw_nxt;
    logic [POW_W-1:0] pow_nxt;
    logic             pending, take_idle_c, apply_c;
    logic [FTW_W-1:0] shadow_ftw;
    logic [POW_W-1:0] shadow_pow;

`ifdef NCO_SWEEP_EN
    logic [FTW_W-1:0] last_ftw, last_ftw_nxt, sweep_sum;
    assign sweep_sum = nco_ftw + sweep_step;
`endif

    nco_cfg_shadow #(.FTW_W(FTW_W), .POW_W(POW_W)) u_shadow (
        .clk         (clk),
        .rst         (rst),
        .state       (state),
        .state_nxt   (state_nxt),
        .sym_stb     (sym_stb),
        .cfg_valid   (cfg.cfg_valid),
        .cfg_ftw     (cfg.cfg_ftw),
        .cfg_pow     (cfg.cfg_pow),
        .cfg_ready   (cfg.cfg_ready),
        .pending     (pending),
        .shadow_ftw  (shadow_ftw),
        .shadow_pow  (shadow_pow),
        .take_idle_c (take_idle_c),
        .apply_c     (apply_c)
    );

    // Next state, settle counter and next values of every registered output.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        if (!run_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:   state_nxt = CLEAR;
                CLEAR:  state_nxt = SETTLE;
                SETTLE: begin
                    cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
                    if ((cnt == CNT_MAX) && nco_valid) state_nxt = RUN;
                end
                RUN:     state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end

        en_nxt  = (state_nxt == SETTLE) || (state_nxt == RUN);
        clr_nxt = (state_nxt == CLEAR);
        cv_nxt  = run_en && (state == RUN) && nco_valid;
        upd_nxt = apply_c;
        err_nxt = err;
        if (!run_en) begin
            err_nxt = 1'b0;
        end else if ((state == RUN) && !nco_valid) begin
            err_nxt = 1'b1;
        end

        ftw_nxt = nco_ftw;
        pow_nxt = nco_pow;
`ifdef NCO_SWEEP_EN
        last_ftw_nxt = last_ftw;
`endif
        if (take_idle_c) begin
            ftw_nxt = cfg.cfg_ftw;
            pow_nxt = cfg.cfg_pow;
`ifdef NCO_SWEEP_EN
            last_ftw_nxt = cfg.cfg_ftw;
`endif
        end else if (apply_c) begin
            ftw_nxt = shadow_ftw;
            pow_nxt = shadow_pow;
`ifdef NCO_SWEEP_EN
            last_ftw_nxt = shadow_ftw;
        end else if (sweep_on && sym_stb && !pending && (state == RUN) && (state_nxt == RUN)) begin
            ftw_nxt = (sweep_sum > sweep_stop) ? last_ftw : sweep_sum;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            nco_en        <= 1'b0;
            nco_clr       <= 1'b0;
            nco_ftw       <= FTW_DEFAULT;
            nco_pow       <= '0;
            carrier_valid <= 1'b0;
            upd_done      <= 1'b0;
            err           <= 1'b0;
`ifdef NCO_SWEEP_EN
            last_ftw      <= FTW_DEFAULT;
`endif
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            nco_en        <= en_nxt;
            nco_clr       <= clr_nxt;
            nco_ftw       <= ftw_nxt;
            nco_pow       <= pow_nxt;
            carrier_valid <= cv_nxt;
            upd_done      <= upd_nxt;
            err           <= err_nxt;
`ifdef NCO_SWEEP_EN
            last_ftw      <= last_ftw_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_nco_seq_ctrl.sv
// Self-checking bench for nco_seq_ctrl with a scenario-level reference model.
module tb_nco_seq_ctrl;

    localparam int unsigned FTW_W      = 32;
    localparam int unsigned POW_W      = 10;
    localparam int unsigned SETTLE_CYC = 8;
    localparam logic [FTW_W-1:0] FTW_DEF = 32'h0800_0000;

    logic             clk = 1'b0;
    logic             rst, run_en, sym_stb, nco_valid;
    logic             nco_en, nco_clr, carrier_valid, upd_done, err;
    logic [FTW_W-1:0] nco_ftw;
    logic [POW_W-1:0] nco_pow;

    int checks = 0;
    int errors = 0;

    // Reference model: what the NCO should currently be programmed with.
    logic [FTW_W-1:0] model_ftw = FTW_DEF;
    logic [POW_W-1:0] model_pow = '0;

    nco_seq_ctrl_if #(.FTW_W(FTW_W), .POW_W(POW_W)) cfg_if ();

    nco_seq_ctrl #(.FTW_W(FTW_W), .POW_W(POW_W), .FTW_DEFAULT(FTW_DEF), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk           (clk),
        .rst           (rst),
        .run_en        (run_en),
        .sym_stb       (sym_stb),
        .nco_valid     (nco_valid),
        .cfg           (cfg_if),
        .nco_en        (nco_en),
        .nco_clr       (nco_clr),
        .nco_ftw       (nco_ftw),
        .nco_pow       (nco_pow),
        .carrier_valid (carrier_valid),
        .upd_done      (upd_done),
        .err           (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_run();
        bit ok;
        run_en = 1'b0; sym_stb = 1'b0; cfg_if.cfg_valid = 1'b0;
        tick(); tick();
        run_en = 1'b1; nco_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            tick();
            if (carrier_valid === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL go_run: carrier_valid got 0 after 30 cycles, expected 1"); end
    endtask

    task automatic test_reset();
        rst = 1'b0; run_en = 1'b0; sym_stb = 1'b0; nco_valid = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ftw = '0; cfg_if.cfg_pow = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({nco_en, nco_clr, carrier_valid, upd_done, err, cfg_if.cfg_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_flags: got en/clr/cv/upd/err/rdy=%b, expected 000001",
                     {nco_en, nco_clr, carrier_valid, upd_done, err, cfg_if.cfg_ready});
        end
        checks++;
        if (nco_ftw !== FTW_DEF) begin errors++; $display("FAIL reset_ftw: got %h, expected %h", nco_ftw, FTW_DEF); end
        checks++;
        if (nco_pow !== '0) begin errors++; $display("FAIL reset_pow: got %h, expected 0", nco_pow); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_startup();
        int clr_cycles, lat;
        run_en = 1'b1;
        tick();
        nco_valid = 1'b1;
        checks++;
        if ({nco_clr, nco_en, cfg_if.cfg_ready} !== 3'b100) begin
            errors++;
            $display("FAIL clear_state: got clr/en/rdy=%b, expected 100", {nco_clr, nco_en, cfg_if.cfg_ready});
        end
        clr_cycles = 1;
        lat = 0;
        for (int e = 1; e <= 30 && lat == 0; e++) begin
            tick();
            if (nco_clr === 1'b1) clr_cycles++;
            if (carrier_valid === 1'b1) lat = e;
        end
        checks++;
        if (lat != SETTLE_CYC + 2) begin errors++; $display("FAIL startup_latency: got %0d, expected %0d", lat, SETTLE_CYC + 2); end
        checks++;
        if (clr_cycles != 1) begin errors++; $display("FAIL clr_pulse_len: got %0d, expected 1", clr_cycles); end
        checks++;
        if (nco_ftw !== FTW_DEF || nco_en !== 1'b1) begin
            errors++; $display("FAIL run_defaults: got ftw=%h en=%b, expected ftw=%h en=1", nco_ftw, nco_en, FTW_DEF);
        end
    endtask

    task automatic test_idle_cfg();
        run_en = 1'b0;
        tick(); tick();
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ftw = 32'h1000_0000; cfg_if.cfg_pow = 10'h100;
        checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b, expected 1", cfg_if.cfg_ready); end
        tick();
        cfg_if.cfg_valid = 1'b0;
        model_ftw = 32'h1000_0000; model_pow = 10'h100;
        checks++;
        if (nco_ftw !== model_ftw || nco_pow !== model_pow || upd_done !== 1'b0) begin
            errors++;
            $display("FAIL idle_load: got ftw=%h pow=%h upd=%b, expected ftw=%h pow=%h upd=0",
                     nco_ftw, nco_pow, upd_done, model_ftw, model_pow);
        end
    endtask

    task automatic test_deferred();
        logic [POW_W-1:0] p;
        int bad;
        go_run();
        p = POW_W'($urandom);
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ftw = 32'h2000_0000; cfg_if.cfg_pow = p;
        tick();
        cfg_if.cfg_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (nco_ftw !== model_ftw || cfg_if.cfg_ready !== 1'b0 || upd_done !== 1'b0) begin
                errors++; bad++;
                if (bad < 4) $display("FAIL deferred_hold: cycle %0d got ftw=%h rdy=%b upd=%b, expected ftw=%h rdy=0 upd=0",
                                      i, nco_ftw, cfg_if.cfg_ready, upd_done, model_ftw);
            end
            tick();
        end
        sym_stb = 1'b1;
        tick();
        sym_stb = 1'b0;
        model_ftw = 32'h2000_0000; model_pow = p;
        checks++;
        if (nco_ftw !== model_ftw || nco_pow !== model_pow || upd_done !== 1'b1) begin
            errors++;
            $display("FAIL deferred_apply: got ftw=%h pow=%h upd=%b, expected ftw=%h pow=%h upd=1",
                     nco_ftw, nco_pow, upd_done, model_ftw, model_pow);
        end
        tick();
        checks++;
        if (upd_done !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
            errors++; $display("FAIL deferred_after: got upd=%b rdy=%b, expected upd=0 rdy=1", upd_done, cfg_if.cfg_ready);
        end
    endtask

    task automatic test_coincident();
        logic [FTW_W-1:0] v;
        logic [POW_W-1:0] p;
        v = FTW_W'($urandom); p = POW_W'($urandom);
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ftw = v; cfg_if.cfg_pow = p; sym_stb = 1'b1;
        tick();
        cfg_if.cfg_valid = 1'b0; sym_stb = 1'b0;
        checks++;
        if (nco_ftw !== model_ftw || upd_done !== 1'b0) begin
            errors++; $display("FAIL coincident_hold: got ftw=%h upd=%b, expected ftw=%h upd=0", nco_ftw, upd_done, model_ftw);
        end
        repeat (3) tick();
        checks++;
        if (nco_ftw !== model_ftw) begin errors++; $display("FAIL coincident_wait: got %h, expected %h", nco_ftw, model_ftw); end
        sym_stb = 1'b1;
        tick();
        sym_stb = 1'b0;
        model_ftw = v; model_pow = p;
        checks++;
        if (nco_ftw !== model_ftw || nco_pow !== model_pow || upd_done !== 1'b1) begin
            errors++;
            $display("FAIL coincident_apply: got ftw=%h pow=%h upd=%b, expected ftw=%h pow=%h upd=1",
                     nco_ftw, nco_pow, upd_done, model_ftw, model_pow);
        end
    endtask

    task automatic test_random();
        bit pend, pend_b, cv, stb, exp_upd;
        logic [FTW_W-1:0] sh_ftw, v;
        logic [POW_W-1:0] sh_pow, p;
        int bad;
        pend = 1'b0; sh_ftw = '0; sh_pow = '0; bad = 0;
        for (int i = 0; i < 300; i++) begin
            checks++;
            if (cfg_if.cfg_ready !== !pend) begin
                errors++; bad++;
                if (bad < 6) $display("FAIL random_ready: cycle %0d got %b, expected %b", i, cfg_if.cfg_ready, !pend);
            end
            cv = ($urandom_range(2) == 0); stb = ($urandom_range(3) == 0);
            v = FTW_W'($urandom); p = POW_W'($urandom);
            cfg_if.cfg_valid = cv; cfg_if.cfg_ftw = v; cfg_if.cfg_pow = p; sym_stb = stb;
            tick();
            pend_b = pend; exp_upd = 1'b0;
            if (pend_b && stb) begin
                model_ftw = sh_ftw; model_pow = sh_pow; pend = 1'b0; exp_upd = 1'b1;
            end
            if (!pend_b && cv) begin
                sh_ftw = v; sh_pow = p; pend = 1'b1;
            end
            checks++;
            if (nco_ftw !== model_ftw || nco_pow !== model_pow || upd_done !== exp_upd) begin
                errors++; bad++;
                if (bad < 6) $display("FAIL random_out: cycle %0d got ftw=%h pow=%h upd=%b, expected ftw=%h pow=%h upd=%b",
                                      i, nco_ftw, nco_pow, upd_done, model_ftw, model_pow, exp_upd);
            end
        end
        cfg_if.cfg_valid = 1'b0; sym_stb = 1'b0;
    endtask

    task automatic test_drop_pending();
        go_run();
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ftw = FTW_W'($urandom); cfg_if.cfg_pow = POW_W'($urandom);
        tick();
        cfg_if.cfg_valid = 1'b0;
        checks++;
        if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL drop_pending_rdy: got %b, expected 0", cfg_if.cfg_ready); end
        run_en = 1'b0; sym_stb = 1'b1;
        tick();
        sym_stb = 1'b0;
        checks++;
        if ({upd_done, nco_en, carrier_valid, cfg_if.cfg_ready} !== 4'b0001 || nco_ftw !== model_ftw) begin
            errors++;
            $display("FAIL drop_pending: got upd/en/cv/rdy=%b ftw=%h, expected 0001 ftw=%h",
                     {upd_done, nco_en, carrier_valid, cfg_if.cfg_ready}, nco_ftw, model_ftw);
        end
    endtask

    task automatic test_valid_drop();
        go_run();
        nco_valid = 1'b0;
        tick();
        nco_valid = 1'b1;
        checks++;
        if (carrier_valid !== 1'b0 || err !== 1'b1) begin
            errors++; $display("FAIL valid_drop: got cv=%b err=%b, expected cv=0 err=1", carrier_valid, err);
        end
        tick();
        checks++;
        if (carrier_valid !== 1'b1 || err !== 1'b1) begin
            errors++; $display("FAIL valid_recover: got cv=%b err=%b, expected cv=1 err=1", carrier_valid, err);
        end
        repeat (5) tick();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b, expected 1", err); end
        run_en = 1'b0;
        tick();
        checks++;
        if ({err, carrier_valid, nco_en} !== 3'b000) begin
            errors++; $display("FAIL err_clear: got err/cv/en=%b, expected 000", {err, carrier_valid, nco_en});
        end
    endtask

    task automatic test_reset_mid();
        bit ok, saw_upd;
        run_en = 1'b0;
        tick();
        run_en = 1'b1; nco_valid = 1'b1;
        tick(); tick();
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ftw = FTW_W'($urandom) | 32'h1; cfg_if.cfg_pow = POW_W'($urandom);
        tick();
        cfg_if.cfg_valid = 1'b0; sym_stb = 1'b1;
        tick();
        sym_stb = 1'b0;
        checks++;
        if (nco_ftw !== model_ftw || upd_done !== 1'b0 || nco_en !== 1'b1 || cfg_if.cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL settle_stb_ignored: got ftw=%h upd=%b en=%b rdy=%b, expected ftw=%h upd=0 en=1 rdy=0",
                     nco_ftw, upd_done, nco_en, cfg_if.cfg_ready, model_ftw);
        end
        #2 rst = 1'b0;
        #1;
        model_ftw = FTW_DEF; model_pow = '0;
        checks++;
        if ({nco_en, nco_clr, carrier_valid, upd_done, err, cfg_if.cfg_ready} !== 6'b000001 ||
            nco_ftw !== FTW_DEF || nco_pow !== '0) begin
            errors++;
            $display("FAIL async_reset: got flags=%b ftw=%h pow=%h, expected 000001 ftw=%h pow=0",
                     {nco_en, nco_clr, carrier_valid, upd_done, err, cfg_if.cfg_ready}, nco_ftw, nco_pow, FTW_DEF);
        end
        #1 rst = 1'b1;
        tick();
        checks++;
        if (nco_clr !== 1'b1 || nco_ftw !== FTW_DEF) begin
            errors++; $display("FAIL restart_clear: got clr=%b ftw=%h, expected clr=1 ftw=%h", nco_clr, nco_ftw, FTW_DEF);
        end
        ok = 1'b0; saw_upd = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            tick();
            if (upd_done === 1'b1) saw_upd = 1'b1;
            if (carrier_valid === 1'b1) ok = 1'b1;
        end
        sym_stb = 1'b1;
        tick();
        sym_stb = 1'b0;
        if (upd_done === 1'b1) saw_upd = 1'b1;
        checks++;
        if (!ok || saw_upd || nco_ftw !== FTW_DEF || cfg_if.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL restart_run: got cv_seen=%b upd_seen=%b ftw=%h rdy=%b, expected 1 0 %h 1",
                     ok, saw_upd, nco_ftw, cfg_if.cfg_ready, FTW_DEF);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_idle_cfg();
        test_deferred();
        test_coincident();
        test_random();
        test_drop_pending();
        test_valid_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
